cache_perf_monitor: RTL

//  Synthesizable event counter unit for data-cache statistics across NUM_CH cache ports.
//  Per channel it counts reads, read hits, writes and write hits.

---
 rtl/cache_perf_monitor.sv | 113 +++++++++++
 1 files changed

// File: rtl/cache_perf_monitor.sv
// Per-channel read/write hit counters with an atomic shadow bank and a muxed read port.
// Latency: counters update at the end of the event cycle; rd_data is 1 cycle after rd_sel. No backpressure.
module cache_perf_monitor #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ev_rd,
    input  logic [NUM_CH-1:0]             ev_wr,
    input  logic [NUM_CH-1:0]             ev_ready,
    input  logic [NUM_CH-1:0]             ev_hit,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          snap,
    input  logic [$clog2(NUM_CH*4)-1:0]   rd_sel,
    output logic [CNT_W-1:0]              rd_data,
    output logic [NUM_CH*4-1:0]           overflow
);

    localparam int NCNT  = NUM_CH * 4;
    localparam int SEL_W = $clog2(NCNT);

    logic [NUM_CH-1:0] prev_ready_q, prev_ready_d;
    logic [NUM_CH-1:0] prev_hit_q,   prev_hit_d;
    logic [NUM_CH-1:0] rise_ready,   rise_hit;
    logic [NCNT-1:0]   inc;

    logic [CNT_W-1:0]  live_q   [NCNT];
    logic [CNT_W-1:0]  live_d   [NCNT];
    logic [CNT_W-1:0]  live_inc [NCNT];
    logic [CNT_W-1:0]  shadow_q [NCNT];
    logic [CNT_W-1:0]  shadow_d [NCNT];
    logic [NCNT-1:0]   ovf_q, ovf_d, ovf_inc;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;

    // Edge flops track the raw levels even while disabled, so a level that rose
    // during enable=0 is never counted once enable returns.
    always_comb begin
        prev_ready_d = ev_ready;
        prev_hit_d   = ev_hit;
        rise_ready   = ev_ready & ~prev_ready_q;
        rise_hit     = ev_hit   & ~prev_hit_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            inc[ch*4 + 0] = rise_ready[ch] & ev_rd[ch];
            inc[ch*4 + 1] = rise_hit[ch]   & ev_rd[ch];
            inc[ch*4 + 2] = rise_ready[ch] & ev_wr[ch];
            inc[ch*4 + 3] = rise_hit[ch]   & ev_wr[ch];
        end
    end

    // live_inc is the post-increment value before clear; snap captures it so
    // that snap+clear in one cycle is a lossless read-and-clear.
    always_comb begin
        ovf_inc = ovf_q;
        for (int i = 0; i < NCNT; i++) begin
            live_inc[i] = live_q[i];
            if (enable && inc[i]) begin
                if (&live_q[i]) begin
                    ovf_inc[i]  = 1'b1;
                    live_inc[i] = (SATURATE != 0) ? live_q[i] : '0;
                end else begin
                    live_inc[i] = live_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ovf_d = clear ? '0 : ovf_inc;
        for (int i = 0; i < NCNT; i++) begin
            live_d[i]   = clear ? '0 : live_inc[i];
            shadow_d[i] = snap ? live_inc[i] : shadow_q[i];
        end
    end

    // Out-of-range selects match no entry and read back as zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data_d = shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_ready_q <= '0;
            prev_hit_q   <= '0;
            ovf_q        <= '0;
            rd_data_q    <= '0;
            for (int i = 0; i < NCNT; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            prev_ready_q <= prev_ready_d;
            prev_hit_q   <= prev_hit_d;
            ovf_q        <= ovf_d;
            rd_data_q    <= rd_data_d;
            for (int i = 0; i < NCNT; i++) begin
                live_q[i]   <= live_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign overflow = ovf_q;

endmodule
